// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD/hex counter.
// Segment patterns are active-high, bit order a (MSB) down to g (LSB).
package bcd_counter_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1110011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Largest value a single digit reaches before wrapping.
    function automatic digit_t digit_max(input int hex);
        return (hex != 0) ? 4'd15 : 4'd9;
    endfunction

    // Limit a loaded digit to the legal range; in hex mode nothing is clipped.
    function automatic digit_t clamp_digit(input digit_t value, input digit_t max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Single-digit 4-bit to 7-segment decoder, active-high outputs.
module seg7_decode
    import bcd_counter_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    // Map every nibble value to its glyph; hex letters use the b/d lowercase forms.
    always_comb begin
        pattern = SEG_BLANK;
        case (value)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = SEG_A;
            4'hB:    pattern = SEG_B;
            4'hC:    pattern = SEG_C;
            4'hD:    pattern = SEG_D;
            4'hE:    pattern = SEG_E;
            4'hF:    pattern = SEG_F;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_counter_7seg.sv
// Multi-digit up/down counter (BCD or hex per digit) with load, enable,
// terminal count, sticky wrap flag and per-digit 7-segment outputs with
// optional leading-zero blanking.
module bcd_counter_7seg
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int HEX    = 0
)
(
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  BLANK_LZ,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  OVF,
    output logic [7*DIGITS-1:0]   seg
);

    localparam digit_t MAX = digit_max(HEX);

    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_next;
    logic [4*DIGITS-1:0] load_value;
    logic                ovf_q;
    logic [DIGITS-1:0]   at_limit;
    logic [DIGITS-1:0]   step;
    logic [DIGITS:1]     zero_from;
    logic [DIGITS-1:0]   blank;
    logic [7*DIGITS-1:0] seg_raw;

    // Carry/borrow chain: a digit steps when enabled and every lower digit sits at its wrap point.
    always_comb begin
        at_limit = '0;
        step     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            at_limit[k] = UP ? (count_q[4*k +: 4] == MAX) : (count_q[4*k +: 4] == 4'd0);
        end
        step[0] = EN;
        for (int k = 1; k < DIGITS; k++) begin
            step[k] = step[k-1] & at_limit[k-1];
        end
    end

    // The whole count wraps exactly when the top digit steps while at its own wrap point.
    always_comb begin
        TC = step[DIGITS-1] & at_limit[DIGITS-1];
    end

    // Per-digit increment/decrement with wrap between MAX and zero.
    always_comb begin
        count_next = count_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (step[k]) begin
                if (UP) begin
                    count_next[4*k +: 4] = (count_q[4*k +: 4] == MAX) ? 4'd0 : count_q[4*k +: 4] + 4'd1;
                end else begin
                    count_next[4*k +: 4] = (count_q[4*k +: 4] == 4'd0) ? MAX : count_q[4*k +: 4] - 4'd1;
                end
            end
        end
    end

    // Loaded digits are clipped into the legal range so BCD mode never holds A-F.
    always_comb begin
        load_value = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_value[4*k +: 4] = clamp_digit(D[4*k +: 4], MAX);
        end
    end

    // Count and sticky wrap flag registers; load takes precedence over counting.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (LOAD) begin
            count_q <= load_value;
            ovf_q   <= 1'b0;
        end else if (EN) begin
            count_q <= count_next;
            if (TC) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        zero_from         = '0;
        blank             = '0;
        zero_from[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (k == DIGITS - 1) begin
                zero_from[k] = (count_q[4*k +: 4] == 4'd0);
            end else begin
                zero_from[k] = zero_from[k+1] & (count_q[4*k +: 4] == 4'd0);
            end
        end
        for (int k = 1; k < DIGITS; k++) begin
            blank[k] = BLANK_LZ & zero_from[k];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            seg7_decode u_decode (
                .value   (count_q[4*g +: 4]),
                .pattern (seg_raw[7*g +: 7])
            );
            assign seg[7*g +: 7] = blank[g] ? SEG_BLANK : seg_raw[7*g +: 7];
        end
    endgenerate

    assign Q   = count_q;
    assign OVF = ovf_q;

endmodule

// File: doc/bcd_counter_7seg.md
Name: bcd_counter_7seg

Overview:
- Multi-digit, parametrised up/down counter with synchronous load, enable, terminal-count and sticky overflow flag.
- Each digit counts mod 10 (BCD mode) or mod 16 (hex mode) and carries/borrows into the next digit.
- One active-high 7-segment pattern per digit is decoded from the registered count, with optional leading-zero blanking.
- Successor to the single-digit 4-bit lab counter; drives the board's multi-digit display directly.

Parameters:
- DIGITS, 2, number of 4-bit digits (1..8).
- HEX, 0, 0 = each digit wraps 9<->0 (BCD); 1 = each digit wraps F<->0.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- CLR  in  1  asynchronous, active-low reset.
- EN  in  1  count enable.
- UP  in  1  1 = count up, 0 = count down.
- LOAD  in  1  synchronous parallel load of D.
- D  in  4*DIGITS  load value, digit k at D[4k+3:4k].
- BLANK_LZ  in  1  1 = blank leading zero digits.
- Q  out  4*DIGITS  registered count, digit k at Q[4k+3:4k].
- TC  out  1  terminal count (combinational).
- OVF  out  1  sticky wrap flag (registered).
- seg  out  7*DIGITS  segments for digit k at seg[7k+6:7k], bit order a(MSB)..g(LSB), 1 = lit.

Behaviour:
- Reset: CLR low forces Q = 0 and OVF = 0 immediately, independent of CLK. Reset mid-count aborts the count with no partial update. After release, the first rising CLK edge acts normally.
- Priority per rising edge: CLR (async) > LOAD > EN. With EN=0 and LOAD=0, Q and OVF hold.
- Load: Q <= D on the edge; OVF <= 0. In BCD mode any D digit >9 is clamped to 9 when loaded. Hex mode loads unmodified.
- Digit max M = 9 (HEX=0) or 15 (HEX=1).
- Counting:
  - Digit 0 steps when EN=1. Digit k>0 steps when EN=1 and every lower digit is at M (UP=1) or at 0 (UP=0).
  - A step wraps M->0 going up and 0->M going down.
- TC = EN & (UP ? all digits == M : all digits == 0). It is a combinational function of Q, EN and UP.
- OVF is set on an edge where TC=1 and LOAD=0, i.e. the whole count wraps. It stays set until LOAD or CLR.
- Segment decode, combinational from Q, valid in the same cycle as Q:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001
  - 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1110011, A:1110111, b:0011111
  - C:1001110, d:0111101, E:1001111, F:1000111
- Blanking: when BLANK_LZ=1, digit k≥1 outputs seg=0000000 if digit k and all higher digits are 0. Digit 0 is never blanked, so 0 displays as a single "0".
- Latency: Q, OVF and seg reflect an edge's action immediately after that edge. TC follows EN/UP combinationally.
- No X propagation: all registers have reset values and every case branch is covered.

Decomposition:
- Shared package bcd_counter_pkg holds:
  - the sixteen 7-bit segment constants (SEG_0..SEG_F) and SEG_BLANK = 0;
  - the digit-max function of HEX.
- Sub-module seg7_decode: 4-bit value in, 7-bit pattern out, instantiated DIGITS times via generate.
- Counter digit chain and blanking logic stay in the top module.

Test Plan:
- Reset: CLR low mid-count with Q=0x47 -> Q=0x00, OVF=0, seg={1111110,1111110} before the next edge. With BLANK_LZ=1, upper seg=0000000.
- BCD up wrap: DIGITS=2, HEX=0, LOAD 0x98, then EN=1, UP=1 -> 0x99 with TC=1, then 0x00 with OVF=1. OVF stays 1 for 5 further counts.
- BCD down/borrow: LOAD 0x10, UP=0, EN=1 -> 0x09, then 0x08. LOAD 0x00 with UP=0 -> TC=1; next edge gives 0x99, OVF=1.
- Load clamp and priority: LOAD=1 and EN=1 with D=0x3A (BCD) -> Q=0x39, OVF cleared, no count that cycle.
- Hex mode: HEX=1, LOAD 0xFE, EN=1, UP=1 -> 0xFF (TC=1, seg F=1000111), then 0x00 with OVF=1.
- Blanking/hold: DIGITS=3, Q=0x005, BLANK_LZ=1 -> digits 2,1 = 0000000, digit 0 = 1011011. EN=0 for 4 edges -> Q unchanged.
